// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register plus RV32I writeback logic. Captures EX/MEM
//   control and ALU result, extracts and extends load data from the
//   synchronous-read data memory (word arrives the cycle the load sits in WB),
//   and produces the register-file write port and forwarding values.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        hold stage / insert bubble (flush wins)
//   ex_mem_*            incoming instruction fields from EX/MEM
//   mem_read_data       raw data-memory word for the load currently in WB
//   wb_valid, wb_rd     WB instruction valid and destination register
//   wb_RegWrite         qualified register write enable
//   wb_write_data       final writeback value
//   wb_misaligned       misaligned load in WB (write suppressed, data 0)
//   retire_count        64-bit retired-instruction counter, present only when
//                       WB_RETIRE_CNT_EN is defined
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      ex_mem_valid,
    input  logic [DATA_WIDTH-1:0]     ex_mem_alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
    input  logic [2:0]                ex_mem_funct3,
    input  logic                      ex_mem_RegWrite,
    input  logic                      ex_mem_MemToReg,
    input  logic [DATA_WIDTH-1:0]     mem_read_data,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      wb_RegWrite,
    output logic [DATA_WIDTH-1:0]     wb_write_data,
    output logic                      wb_misaligned
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]               retire_count
`endif
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     alu_result_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [2:0]                funct3_q;
    logic                      reg_write_q;
    logic                      mem_to_reg_q;
    logic [DATA_WIDTH-1:0]     hold_data;
    logic                      hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            hold_data    <= '0;
            hold_valid   <= 1'b0;
        end else begin
            if (flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
            end else if (!stall) begin
                valid_q      <= ex_mem_valid;
                alu_result_q <= ex_mem_alu_result;
                rd_q         <= ex_mem_rd;
                funct3_q     <= ex_mem_funct3;
                reg_write_q  <= ex_mem_RegWrite;
                mem_to_reg_q <= ex_mem_MemToReg;
            end

            // The memory only presents the load word for one cycle; a stalled
            // load latches it on the first stalled edge and keeps it.
            if (flush || !stall) begin
                hold_valid <= 1'b0;
            end else if (valid_q && mem_to_reg_q && !hold_valid) begin
                hold_data  <= mem_read_data;
                hold_valid <= 1'b1;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (valid_q && !stall) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

    logic [DATA_WIDTH-1:0] raw_word;
    logic [DATA_WIDTH-1:0] byte_shift;
    logic [DATA_WIDTH-1:0] half_shift;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  misaligned;

    always_comb begin
        raw_word   = hold_valid ? hold_data : mem_read_data;
        off        = alu_result_q[1:0];
        byte_shift = raw_word >> {off, 3'b000};
        half_shift = raw_word >> {off[1], 4'b0000};
        byte_v     = byte_shift[7:0];
        half_v     = half_shift[15:0];

        case (funct3_q)
            F3_LB:   load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            F3_LH:   load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: load_data = raw_word;
        endcase

        misaligned = valid_q && mem_to_reg_q &&
                     ((((funct3_q == F3_LH) || (funct3_q == F3_LHU)) && off[0]) ||
                      ((funct3_q == F3_LW) && (off != 2'b00)));

        wb_valid      = valid_q;
        wb_rd         = rd_q;
        wb_misaligned = misaligned;
        wb_RegWrite   = valid_q && reg_write_q && (rd_q != '0) && !misaligned;
        if (misaligned)
            wb_write_data = '0;
        else if (mem_to_reg_q)
            wb_write_data = load_data;
        else
            wb_write_data = alu_result_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic        ex_mem_valid, ex_mem_RegWrite, ex_mem_MemToReg;
    logic [31:0] ex_mem_alu_result, mem_read_data;
    logic [4:0]  ex_mem_rd;
    logic [2:0]  ex_mem_funct3;
    logic        wb_valid, wb_RegWrite, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rd(ex_mem_rd), .ex_mem_funct3(ex_mem_funct3),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_MemToReg(ex_mem_MemToReg),
        .mem_read_data(mem_read_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .wb_write_data(wb_write_data), .wb_misaligned(wb_misaligned)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic        m2r;
    } instr_t;

    instr_t          m_wb;
    logic            m_held;
    logic [31:0]     m_held_word;
    longint unsigned m_retire;

    task automatic model_reset();
        m_wb = '0; m_held = 1'b0; m_held_word = '0; m_retire = 0;
    endtask

    task automatic model_update();
        instr_t in_i;
        in_i = '{ex_mem_valid, ex_mem_alu_result, ex_mem_rd, ex_mem_funct3,
                 ex_mem_RegWrite, ex_mem_MemToReg};
        if (m_wb.valid && !stall) m_retire++;
        if (flush || !stall) m_held = 1'b0;
        else if (m_wb.valid && m_wb.m2r && !m_held) begin
            m_held = 1'b1;
            m_held_word = mem_read_data;
        end
        if (flush) begin
            m_wb.valid = 1'b0;
            m_wb.rw = 1'b0;
        end else if (!stall) m_wb = in_i;
    endtask

    function automatic logic exp_mis();
        int unsigned off = m_wb.alu % 4;
        exp_mis = m_wb.valid && m_wb.m2r &&
                  ((((m_wb.f3 == 1) || (m_wb.f3 == 5)) && (off % 2 == 1)) ||
                   ((m_wb.f3 == 2) && (off != 0)));
    endfunction

    function automatic logic [31:0] exp_data();
        int unsigned raw, off, b, h;
        raw = m_held ? m_held_word : mem_read_data;
        off = m_wb.alu % 4;
        b = (raw >> (8 * off)) % 256;
        h = (raw >> (16 * (off / 2))) % 65536;
        if (exp_mis()) return 32'h0;
        if (!m_wb.m2r) return m_wb.alu;
        case (m_wb.f3)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic exp_rw();
        exp_rw = m_wb.valid && m_wb.rw && (m_wb.rd != 0) && !exp_mis();
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] r,
                         input logic [2:0] f, input logic rw, input logic m);
        ex_mem_valid = v; ex_mem_alu_result = a; ex_mem_rd = r;
        ex_mem_funct3 = f; ex_mem_RegWrite = rw; ex_mem_MemToReg = m;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        drive(1, 32'hABCD, 7, 0, 1, 0);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({wb_valid, wb_rd, wb_RegWrite, wb_write_data, wb_misaligned} !== 40'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%0b rd=%0d rw=%0b d=%h mis=%0b, want all 0",
                     wb_valid, wb_rd, wb_RegWrite, wb_write_data, wb_misaligned);
        end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_rd, wb_RegWrite, wb_write_data, wb_misaligned} !== 40'h0) begin
            errors++;
            $display("FAIL reset_held: got v=%0b d=%h, want 0", wb_valid, wb_write_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({wb_valid, wb_RegWrite, wb_write_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_release: got v=%0b d=%h, want 0", wb_valid, wb_write_data);
        end
`ifdef WB_RETIRE_CNT_EN
        checks++;
        if (retire_count !== 64'd0) begin
            errors++;
            $display("FAIL reset_retire: got %0d want 0", retire_count);
        end
`endif
    endtask

    task automatic test_alu();
        drive(1, 32'h0000_1234, 3, 0, 1, 0);
        tick(); #1;
        checks++;
        if ({wb_valid, wb_rd, wb_RegWrite, wb_write_data} !== {1'b1, 5'd3, 1'b1, 32'h0000_1234}) begin
            errors++;
            $display("FAIL alu_wb: got v=%0b rd=%0d rw=%0b d=%h, want 1/3/1/00001234",
                     wb_valid, wb_rd, wb_RegWrite, wb_write_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs[4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002};
        logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            drive(1, adrs[i], 5, f3s[i], 1, 1);
            tick();
            mem_read_data = 32'h80FF_7F01;
            #1;
            checks++;
            if ({wb_RegWrite, wb_misaligned, wb_write_data} !== {1'b1, 1'b0, exps[i]}) begin
                errors++;
                $display("FAIL load_f3_%0d: got rw=%0b mis=%0b d=%h, want 1/0/%h",
                         f3s[i], wb_RegWrite, wb_misaligned, wb_write_data, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [2] = '{3'd2, 3'd1};
        logic [31:0] adrs[2] = '{32'h0000_0102, 32'h0000_0101};
        for (int i = 0; i < 2; i++) begin
            drive(1, adrs[i], 7, f3s[i], 1, 1);
            tick();
            mem_read_data = $urandom;
            #1;
            checks++;
            if ({wb_misaligned, wb_RegWrite, wb_write_data} !== {1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL misaligned_%0d: got mis=%0b rw=%0b d=%h, want 1/0/0",
                         i, wb_misaligned, wb_RegWrite, wb_write_data);
            end
        end
    endtask

    task automatic test_stall_hold();
        drive(1, 32'h200, 9, 2, 1, 1);
        stall = 0; flush = 0;
        tick();
        mem_read_data = 32'hDEAD_BEEF;
        stall = 1;
        drive(1, 32'h55, 4, 0, 1, 0);
        #1;
        checks++;
        if (wb_write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL hold_first: got %h want deadbeef", wb_write_data);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            mem_read_data = 32'h0;
            #1;
            checks++;
            if ({wb_valid, wb_rd, wb_write_data} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL hold_stall_%0d: got v=%0b rd=%0d d=%h want 1/9/deadbeef",
                         c, wb_valid, wb_rd, wb_write_data);
            end
        end
        stall = 0;
        #1;
        checks++;
        if (wb_write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL hold_release: got %h want deadbeef", wb_write_data);
        end
        tick(); #1;
        checks++;
        if ({wb_rd, wb_write_data} !== {5'd4, 32'h55}) begin
            errors++;
            $display("FAIL hold_next: got rd=%0d d=%h want 4/00000055", wb_rd, wb_write_data);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 32'h300, 6, 2, 1, 1);
        stall = 1; flush = 1;
        tick(); #1;
        checks++;
        if ({wb_valid, wb_RegWrite} !== 2'b00) begin
            errors++;
            $display("FAIL stall_flush: got v=%0b rw=%0b want 0/0", wb_valid, wb_RegWrite);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_rd0();
        drive(1, 32'h77, 0, 0, 1, 0);
        tick(); #1;
        checks++;
        if ({wb_valid, wb_RegWrite} !== 2'b10) begin
            errors++;
            $display("FAIL rd0: got v=%0b rw=%0b want 1/0", wb_valid, wb_RegWrite);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 10) == 0;
            drive($urandom % 5 != 0, $urandom, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom));
            tick();
            mem_read_data = $urandom;
            #1;
            checks++;
            if ({wb_valid, wb_RegWrite, wb_misaligned} !== {m_wb.valid, exp_rw(), exp_mis()}) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: got v=%0b rw=%0b mis=%0b want %0b/%0b/%0b",
                         c, wb_valid, wb_RegWrite, wb_misaligned, m_wb.valid, exp_rw(), exp_mis());
            end
            if (m_wb.valid) begin
                checks++;
                if ({wb_rd, wb_write_data} !== {m_wb.rd, exp_data()}) begin
                    errors++;
                    $display("FAIL rand_data c=%0d: got rd=%0d d=%h want rd=%0d d=%h",
                             c, wb_rd, wb_write_data, m_wb.rd, exp_data());
                end
            end
`ifdef WB_RETIRE_CNT_EN
            checks++;
            if (retire_count !== m_retire) begin
                errors++;
                $display("FAIL rand_retire c=%0d: got %0d want %0d", c, retire_count, m_retire);
            end
`endif
        end
        stall = 0; flush = 0;
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0; flush = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i), 5'(i + 1), 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick(); #1;
        checks++;
        if (retire_count !== 64'd4) begin
            errors++;
            $display("FAIL retire_four: got %0d want 4", retire_count);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_read_data = '0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu();
        test_loads();
        test_misaligned();
        test_stall_hold();
        test_stall_flush();
        test_rd0();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
